video_stream_gen: RTL and testbench



---
 rtl/video_stream_gen.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_video_stream_gen.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_gen.sv
// video_stream_gen: synthetic video source driving a di/de/hs/vs style
// interface. Active and blanking geometry and the test pattern are
// programmable at runtime and latched once per frame; the pixel cadence
// (DE_PERIOD) is fixed at compile time.
// Optional build macro VIDEO_STREAM_GEN_FRAME_CNT_EN adds a 16-bit frame_cnt
// output and turns pattern 1 into a ramp that scrolls by one step per frame.
module video_stream_gen #(
  parameter int DE_PERIOD  = 0,
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CNT_WIDTH-1:0]  h_active,
  input  logic [CNT_WIDTH-1:0]  h_blank,
  input  logic [CNT_WIDTH-1:0]  v_active,
  input  logic [CNT_WIDTH-1:0]  v_blank,
  input  logic [1:0]            pattern,
  output logic [DATA_WIDTH-1:0] do_o,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  frame_done,
  output logic                  cfg_err
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
  ,
  output logic [15:0]           frame_cnt
`endif
);

  // Slot length in clocks, slot counter width, and a line-length width wide
  // enough for h_active*P + h_blank without overflow.
  localparam int P  = (DE_PERIOD > 1) ? DE_PERIOD : 1;
  localparam int SW = (P > 1) ? $clog2(P) : 1;
  localparam int LW = CNT_WIDTH + SW + 1;

  typedef enum logic [2:0] {IDLE, LEAD, ACT, HBL, VBL} state_t;

  state_t                 state_reg, state_next;
  logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;     // LEAD/HBL cycle counter
  logic [CNT_WIDTH-1:0]   x_reg, x_next;         // pixel index in line
  logic [CNT_WIDTH-1:0]   y_reg, y_next;         // line index (blank line index in VBL)
  logic [SW-1:0]          slot_reg, slot_next;   // cycle within a pixel slot
  logic [LW-1:0]          lcnt_reg, lcnt_next;   // cycle within a blank line

  // Latched frame configuration
  logic [CNT_WIDTH-1:0]   ha_reg, hb_reg, va_reg, vb_reg;
  logic [1:0]             pat_reg;
  logic [LW-1:0]          line_len_reg;

  logic                   cfg_valid;
  logic [CNT_WIDTH-1:0]   hb_in;
  logic [LW-1:0]          line_len_in;
  logic                   latch_cfg;
  logic                   err_set;

  logic [DATA_WIDTH-1:0]  do_reg, do_next;
  logic                   de_reg, de_next;
  logic                   hs_reg, hs_next;
  logic                   vs_reg, vs_next;
  logic                   fd_reg, fd_next;
  logic                   cfg_err_reg;

  logic [DATA_WIDTH-1:0]  checker_word;
  logic [DATA_WIDTH-1:0]  pix_value;

  // A zero h_blank still needs one blanking cycle so hs_o is visible.
  assign cfg_valid   = (h_active != '0) && (v_active != '0);
  assign hb_in       = (h_blank == '0) ? CNT_WIDTH'(1) : h_blank;
  assign line_len_in = LW'(h_active) * LW'(P) + LW'(hb_in);

`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;

  // Frame counter advances with every frame_done pulse and wraps freely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_cnt_reg <= '0;
    else if (fd_next) frame_cnt_reg <= frame_cnt_reg + 16'd1;
  end

  assign frame_cnt = frame_cnt_reg;
`endif

  // Checker tile bit replicated across the whole pixel word (8x8 tiles).
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_checker
    assign checker_word[gi] = x_reg[3] ^ y_reg[3];
  end

  // Pixel value for the current x/y under the latched pattern.
  always_comb begin
    pix_value = '0;
    case (pat_reg)
      2'd0: pix_value = DATA_WIDTH'(x_reg);
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
      2'd1: pix_value = DATA_WIDTH'(y_reg) + DATA_WIDTH'(frame_cnt_reg);
`else
      2'd1: pix_value = DATA_WIDTH'(y_reg);
`endif
      2'd2: pix_value = checker_word;
      default: pix_value = DATA_WIDTH'(x_reg) + DATA_WIDTH'(y_reg);
    endcase
  end

  // State and counter registers, plus the per-frame configuration latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      slot_reg     <= '0;
      lcnt_reg     <= '0;
      ha_reg       <= '0;
      hb_reg       <= '0;
      va_reg       <= '0;
      vb_reg       <= '0;
      pat_reg      <= '0;
      line_len_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      slot_reg  <= slot_next;
      lcnt_reg  <= lcnt_next;
      if (latch_cfg) begin
        ha_reg       <= h_active;
        hb_reg       <= hb_in;
        va_reg       <= v_active;
        vb_reg       <= v_blank;
        pat_reg      <= pattern;
        line_len_reg <= line_len_in;
      end
    end
  end

  // Next-state and counter sequencing; en is only looked at in IDLE and at
  // the last VBL cycle, so mid-frame en/config changes are ignored.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    slot_next  = slot_reg;
    lcnt_next  = lcnt_reg;
    latch_cfg  = 1'b0;
    err_set    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en) begin
          if (cfg_valid) begin
            state_next = LEAD;
            latch_cfg  = 1'b1;
            cnt_next   = '0;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      LEAD: begin
        if (cnt_reg == hb_reg - CNT_WIDTH'(1)) begin
          state_next = ACT;
          cnt_next   = '0;
          x_next     = '0;
          y_next     = '0;
          slot_next  = '0;
        end else begin
          cnt_next = cnt_reg + CNT_WIDTH'(1);
        end
      end
      ACT: begin
        if (slot_reg == SW'(P - 1)) begin
          slot_next = '0;
          if (x_reg == ha_reg - CNT_WIDTH'(1)) begin
            state_next = HBL;
            cnt_next   = '0;
          end else begin
            x_next = x_reg + CNT_WIDTH'(1);
          end
        end else begin
          slot_next = slot_reg + SW'(1);
        end
      end
      HBL: begin
        if (cnt_reg == hb_reg - CNT_WIDTH'(1)) begin
          cnt_next = '0;
          if (y_reg == va_reg - CNT_WIDTH'(1)) begin
            state_next = VBL;
            y_next     = '0;
            lcnt_next  = '0;
          end else begin
            state_next = ACT;
            y_next     = y_reg + CNT_WIDTH'(1);
            x_next     = '0;
            slot_next  = '0;
          end
        end else begin
          cnt_next = cnt_reg + CNT_WIDTH'(1);
        end
      end
      VBL: begin
        if ((vb_reg == '0) ||
            ((lcnt_reg == line_len_reg - LW'(1)) && (y_reg == vb_reg - CNT_WIDTH'(1)))) begin
          if (en && cfg_valid) begin
            state_next = LEAD;
            latch_cfg  = 1'b1;
            cnt_next   = '0;
          end else begin
            state_next = IDLE;
            err_set    = en;
          end
        end else if (lcnt_reg == line_len_reg - LW'(1)) begin
          lcnt_next = '0;
          y_next    = y_reg + CNT_WIDTH'(1);
        end else begin
          lcnt_next = lcnt_reg + LW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the current state; do_o holds between pixels.
  always_comb begin
    do_next = do_reg;
    de_next = 1'b0;
    hs_next = 1'b0;
    vs_next = 1'b0;
    fd_next = 1'b0;
    case (state_reg)
      IDLE: do_next = '0;
      LEAD: begin
        vs_next = 1'b1;
        hs_next = 1'b1;
      end
      ACT: begin
        vs_next = 1'b1;
        if (slot_reg == '0) begin
          de_next = 1'b1;
          do_next = pix_value;
        end
      end
      HBL: begin
        vs_next = 1'b1;
        hs_next = 1'b1;
      end
      VBL: begin
        hs_next = 1'b1;
        fd_next = (lcnt_reg == '0) && (y_reg == '0);
      end
      default: do_next = '0;
    endcase
  end

  // Output registers: everything leaves the block one cycle after decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      do_reg <= '0;
      de_reg <= 1'b0;
      hs_reg <= 1'b0;
      vs_reg <= 1'b0;
      fd_reg <= 1'b0;
    end else begin
      do_reg <= do_next;
      de_reg <= de_next;
      hs_reg <= hs_next;
      vs_reg <= vs_next;
      fd_reg <= fd_next;
    end
  end

  // Sticky configuration error, released only by dropping en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cfg_err_reg <= 1'b0;
    else if (!en) cfg_err_reg <= 1'b0;
    else if (err_set) cfg_err_reg <= 1'b1;
  end

  assign do_o       = do_reg;
  assign de_o       = de_reg;
  assign hs_o       = hs_reg;
  assign vs_o       = vs_reg;
  assign frame_done = fd_reg;
  assign cfg_err    = cfg_err_reg;

endmodule

// File: tb/tb_video_stream_gen.sv
// Bench for video_stream_gen: two instances (one pixel per clock and one
// pixel every 4 clocks) share all inputs. A frame-position model predicts
// every output on every cycle; directed steps add literal expectations.
`timescale 1ns/1ps
module tb_video_stream_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] h_active = 16'd8;
  logic [15:0] h_blank = 16'd3;
  logic [15:0] v_active = 16'd4;
  logic [15:0] v_blank = 16'd2;
  logic [1:0]  pattern = 2'd0;

  logic [11:0] do0, do4;
  logic        de0, hs0, vs0, fd0, err0;
  logic        de4, hs4, vs4, fd4, err4;
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
  logic [15:0] fc0, fc4;
  localparam int FC_ON = 1;
`else
  localparam int FC_ON = 0;
`endif

  always #5 clk = ~clk;

  video_stream_gen #(.DE_PERIOD(0), .DATA_WIDTH(12), .CNT_WIDTH(16)) u_p1 (
    .clk(clk), .rst(rst), .en(en),
    .h_active(h_active), .h_blank(h_blank), .v_active(v_active), .v_blank(v_blank),
    .pattern(pattern),
    .do_o(do0), .de_o(de0), .hs_o(hs0), .vs_o(vs0), .frame_done(fd0), .cfg_err(err0)
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
    , .frame_cnt(fc0)
`endif
  );

  video_stream_gen #(.DE_PERIOD(4), .DATA_WIDTH(12), .CNT_WIDTH(16)) u_p4 (
    .clk(clk), .rst(rst), .en(en),
    .h_active(h_active), .h_blank(h_blank), .v_active(v_active), .v_blank(v_blank),
    .pattern(pattern),
    .do_o(do4), .de_o(de4), .hs_o(hs4), .vs_o(vs4), .frame_done(fd4), .cfg_err(err4)
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
    , .frame_cnt(fc4)
`endif
  );

  int n_pass = 0;
  int n_total = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t actual=%0d required=%0d", nm, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Each running frame is a timeline t = 0..T-1:
  //   [lead B][line0: A act + B blank]...[line va-1][vblank V]
  // with B = max(hb,1), A = ha*P, L = A+B, V = max(vb*L,1).
  int m_run [2];
  int m_t   [2];
  int m_ha  [2];
  int m_hb  [2];
  int m_va  [2];
  int m_vb  [2];
  int m_pat [2];
  int m_fc  [2];
  int e_do  [2];
  int e_de  [2];
  int e_hs  [2];
  int e_vs  [2];
  int e_fd  [2];
  int e_err [2];

  function automatic int pix(input int pat, input int x, input int y, input int fc);
    case (pat)
      0: return x % 4096;
      1: return (y + FC_ON * fc) % 4096;
      2: return (((x / 8) ^ (y / 8)) % 2 == 1) ? 4095 : 0;
      default: return (x + y) % 4096;
    endcase
  endfunction

  task automatic model_step(input int k);
    int p, b, a, l, v, t_len, u, r;
    bit valid, last;
    p = (k == 0) ? 1 : 4;
    valid = (h_active != 0) && (v_active != 0);
    b = (m_hb[k] == 0) ? 1 : m_hb[k];
    a = m_ha[k] * p;
    l = a + b;
    v = (m_vb[k] == 0) ? 1 : m_vb[k] * l;
    t_len = b + m_va[k] * l + v;
    last = (m_run[k] != 0) && (m_t[k] == t_len - 1);
    e_de[k] = 0; e_hs[k] = 0; e_vs[k] = 0; e_fd[k] = 0;
    if (m_run[k] == 0) begin
      e_do[k] = 0;
    end else if (m_t[k] < b) begin
      e_vs[k] = 1; e_hs[k] = 1;
    end else begin
      u = m_t[k] - b;
      if (u < m_va[k] * l) begin
        r = u % l;
        e_vs[k] = 1;
        if (r < a) begin
          if (r % p == 0) begin
            e_de[k] = 1;
            e_do[k] = pix(m_pat[k], r / p, u / l, m_fc[k]);
          end
        end else begin
          e_hs[k] = 1;
        end
      end else begin
        e_hs[k] = 1;
        if (u == m_va[k] * l) begin
          e_fd[k] = 1;
          m_fc[k] = (m_fc[k] + 1) % 65536;
        end
      end
    end
    if (!en) e_err[k] = 0;
    else if (((m_run[k] == 0) || last) && !valid) e_err[k] = 1;
    if ((m_run[k] == 0) || last) begin
      if (en && valid) begin
        m_run[k] = 1; m_t[k] = 0;
        m_ha[k] = h_active; m_hb[k] = h_blank; m_va[k] = v_active;
        m_vb[k] = v_blank; m_pat[k] = pattern;
      end else begin
        m_run[k] = 0;
      end
    end else begin
      m_t[k] = m_t[k] + 1;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_run[k] = 0; m_t[k] = 0; m_fc[k] = 0;
        e_do[k] = 0; e_de[k] = 0; e_hs[k] = 0; e_vs[k] = 0; e_fd[k] = 0; e_err[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  // ---------------- per-cycle comparison ----------------
  task automatic cmp_dut(input int k, input int d, input int de, input int hs,
                         input int vs, input int fd, input int err);
    chk($sformatf("u%0d.do_o", k), d, e_do[k]);
    chk($sformatf("u%0d.de_o", k), de, e_de[k]);
    chk($sformatf("u%0d.hs_o", k), hs, e_hs[k]);
    chk($sformatf("u%0d.vs_o", k), vs, e_vs[k]);
    chk($sformatf("u%0d.frame_done", k), fd, e_fd[k]);
    chk($sformatf("u%0d.cfg_err", k), err, e_err[k]);
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      cmp_dut(0, int'(do0), int'(de0), int'(hs0), int'(vs0), int'(fd0), int'(err0));
      cmp_dut(1, int'(do4), int'(de4), int'(hs4), int'(vs4), int'(fd4), int'(err4));
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
      chk("u0.frame_cnt", int'(fc0), m_fc[0]);
      chk("u1.frame_cnt", int'(fc4), m_fc[1]);
`endif
    end
  end

  // ---------------- monitor for literal checks ----------------
  int de_tot0 = 0, de_tot4 = 0, fd_tot0 = 0;
  int hi_run0 = 0, last_hi0 = 0, lo_run0 = 0, last_lo0 = 0;
  int ring0 [1024];
  int ring4 [64];

  always @(negedge clk) begin
    if (de0) begin
      ring0[de_tot0 % 1024] <= int'(do0);
      de_tot0 <= de_tot0 + 1;
    end
    if (de4) begin
      ring4[de_tot4 % 64] <= int'(do4);
      de_tot4 <= de_tot4 + 1;
    end
    if (fd0) fd_tot0 <= fd_tot0 + 1;
    if (vs0) hi_run0 <= hi_run0 + 1;
    else begin
      if (hi_run0 != 0) last_hi0 <= hi_run0;
      hi_run0 <= 0;
    end
    if (!vs0) lo_run0 <= lo_run0 + 1;
    else begin
      if (lo_run0 != 0) last_lo0 <= lo_run0;
      lo_run0 <= 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_fd(input int k, input int bound, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(posedge clk); #2;
      got = (k == 0) ? fd0 : fd4;
    end
    chk(nm, int'(got), 1);
    @(negedge clk); #1;
  endtask

  task automatic wait_idle(input int bound, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(posedge clk); #2;
      got = !vs0 && !hs0 && !vs4 && !hs4;
    end
    chk(nm, int'(got), 1);
    @(negedge clk); #1;
  endtask

  task automatic set_cfg(input int ha, input int hb, input int va, input int vb, input int pat);
    h_active = 16'(ha); h_blank = 16'(hb); v_active = 16'(va); v_blank = 16'(vb);
    pattern = 2'(pat);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base, base4, fdb;
    #1 rst = 1'b0;
    #1;
    chk("reset.do_o", int'(do0), 0);
    chk("reset.de_o", int'(de0), 0);
    chk("reset.vs_o", int'(vs0), 0);
    chk("reset.hs_o", int'(hs0), 0);
    chk("reset.frame_done", int'(fd0), 0);
    chk("reset.cfg_err", int'(err4), 0);
    cmp_on = 1'b1;
    cycles(3);
    rst = 1'b1;
    cycles(3);

    $display("step 1: 8x4 frames, hblank 3, vblank 2, x ramp");
    set_cfg(8, 3, 4, 2, 0);
    base = de_tot0;
    fdb = fd_tot0;
    en = 1'b1;
    wait_fd(0, 200, "t1.fd1_timeout");
    chk("t1.vs_high_len", last_hi0, 47);
    chk("t1.de_per_frame", de_tot0 - base, 32);
    chk("t1.line0_px0", ring0[base % 1024], 0);
    chk("t1.line0_px7", ring0[(base + 7) % 1024], 7);
    chk("t1.line1_px3", ring0[(base + 11) % 1024], 3);
    wait_fd(0, 200, "t1.fd2_timeout");
    chk("t1.vs_low_len", last_lo0, 22);
    chk("t1.fd_count", fd_tot0 - fdb, 2);
    en = 1'b0;
    wait_idle(1000, "t1.idle_timeout");

    $display("step 2: DE_PERIOD 4 instance, 5 pixels per line, y ramp");
    set_cfg(5, 3, 4, 2, 1);
    base4 = de_tot4;
    en = 1'b1;
    wait_fd(1, 400, "t2.fd_timeout");
    chk("t2.de_per_frame", de_tot4 - base4, 20);
    chk("t2.line0_px4", ring4[(base4 + 4) % 64], 0);
    chk("t2.line1_px0", ring4[(base4 + 5) % 64], 1);
    chk("t2.line3_px4", ring4[(base4 + 19) % 64], 3);
    en = 1'b0;
    wait_idle(1000, "t2.idle_timeout");

    $display("step 3: checker 32x16");
    set_cfg(32, 3, 16, 1, 2);
    base = de_tot0;
    en = 1'b1;
    wait_fd(0, 1000, "t3.fd_timeout");
    en = 1'b0;
    chk("t3.l0_x0", ring0[base % 1024], 0);
    chk("t3.l0_x8", ring0[(base + 8) % 1024], 4095);
    chk("t3.l8_x0", ring0[(base + 256) % 1024], 4095);
    chk("t3.l8_x8", ring0[(base + 264) % 1024], 0);
    wait_idle(3000, "t3.idle_timeout");

    $display("step 4: v_active 0 raises cfg_err");
    set_cfg(8, 3, 0, 2, 0);
    en = 1'b1;
    cycles(3);
    chk("t4.cfg_err_u0", int'(err0), 1);
    chk("t4.cfg_err_u1", int'(err4), 1);
    chk("t4.vs_o", int'(vs0), 0);
    en = 1'b0;
    cycles(2);
    chk("t4.cfg_err_clear", int'(err0), 0);

    $display("step 5: en dropped mid-frame, x+y pattern");
    set_cfg(8, 3, 4, 2, 3);
    fdb = fd_tot0;
    en = 1'b1;
    cycles(10);
    en = 1'b0;
    wait_fd(0, 200, "t5.fd_timeout");
    wait_idle(1000, "t5.idle_timeout");
    chk("t5.fd_count", fd_tot0 - fdb, 1);
    chk("t5.idle_do", int'(do0), 0);
    chk("t5.idle_hs", int'(hs0), 0);

    $display("step 6: asynchronous reset mid-line");
    en = 1'b1;
    begin
      bit got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
        @(posedge clk); #2;
        got = de0;
      end
      chk("t6.de_timeout", int'(got), 1);
    end
    rst = 1'b0;
    #1;
    chk("t6.rst_de", int'(de0), 0);
    chk("t6.rst_vs", int'(vs0), 0);
    chk("t6.rst_do", int'(do0), 0);
    chk("t6.rst_vs_u1", int'(vs4), 0);
    en = 1'b0;
    cycles(3);
    rst = 1'b1;
    base = de_tot0;
    cycles(20);
    chk("t6.no_output", de_tot0 - base, 0);
    chk("t6.vs_after", int'(vs0), 0);

`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
    $display("step 7: scrolling y ramp over three frames");
    set_cfg(8, 3, 4, 2, 1);
    base = de_tot0;
    en = 1'b1;
    wait_fd(0, 200, "t7.fd1_timeout");
    wait_fd(0, 200, "t7.fd2_timeout");
    wait_fd(0, 200, "t7.fd3_timeout");
    en = 1'b0;
    chk("t7.f0_line0", ring0[base % 1024], 0);
    chk("t7.f1_line0", ring0[(base + 32) % 1024], 1);
    chk("t7.f2_line0", ring0[(base + 64) % 1024], 2);
    chk("t7.frame_cnt", int'(fc0), 3);
    wait_idle(1000, "t7.idle_timeout");
`endif

    cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
